// File: rtl/divider32fp.sv
// Iterative IEEE-754 single-precision divider (quotient_o = a_i / b_i).
// Radix-2 restoring mantissa division that produces one quotient bit per clock.
// Rounding is truncation toward zero. Subnormal operands are flushed to zero.
module divider32fp #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [EXP_W+MAN_W:0]     a_i,
    input  logic [EXP_W+MAN_W:0]     b_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     nan_o,
    output logic                     infinit_o,
    output logic                     div_zero_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    output logic [EXP_W+MAN_W:0]     quotient_o
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int CNT_W = $clog2(MAN_W + 2);
    localparam logic signed [EXP_W+1:0] BIAS_X    = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] EXP_MAX_X = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] ZERO_X    = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORMALIZE,
        S_PACK,
        S_DONE
    } state_t;

    state_t                   state;
    logic [W-1:0]             a_reg;
    logic [W-1:0]             b_reg;
    logic                     sign;
    logic signed [EXP_W+1:0]  exp_q;
    logic [MAN_W+1:0]         rem;
    logic [MAN_W:0]           mb;
    logic [MAN_W+1:0]         q;
    logic [CNT_W-1:0]         cnt;
    logic                     is_special;
    logic [W-1:0]             pend_result;
    logic                     pend_nan;
    logic                     pend_inf;
    logic                     pend_dz;

    logic [EXP_W-1:0]         ea;
    logic [EXP_W-1:0]         eb;
    logic [MAN_W-1:0]         fa;
    logic [MAN_W-1:0]         fb;
    logic                     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [EXP_W+1:0]  exp_diff;
    logic                     rem_ge;
    logic [MAN_W+1:0]         rem_next;

    // Operand field extraction, classification and one restoring-division step
    always_comb begin
        ea       = a_reg[W-2 -: EXP_W];
        eb       = b_reg[W-2 -: EXP_W];
        fa       = a_reg[MAN_W-1:0];
        fb       = b_reg[MAN_W-1:0];
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        a_inf    = (ea == '1) && (fa == '0);
        b_inf    = (eb == '1) && (fb == '0);
        a_nan    = (ea == '1) && (fa != '0);
        b_nan    = (eb == '1) && (fb != '0);
        exp_diff = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_X;
        rem_ge   = (rem >= {1'b0, mb});
        rem_next = rem_ge ? (rem - {1'b0, mb}) : rem;
    end

    // Control FSM with the datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sign        <= 1'b0;
            exp_q       <= '0;
            rem         <= '0;
            mb          <= '0;
            q           <= '0;
            cnt         <= '0;
            is_special  <= 1'b0;
            pend_result <= '0;
            pend_nan    <= 1'b0;
            pend_inf    <= 1'b0;
            pend_dz     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            nan_o       <= 1'b0;
            infinit_o   <= 1'b0;
            div_zero_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            quotient_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        a_reg       <= a_i;
                        b_reg       <= b_i;
                        nan_o       <= 1'b0;
                        infinit_o   <= 1'b0;
                        div_zero_o  <= 1'b0;
                        overflow_o  <= 1'b0;
                        underflow_o <= 1'b0;
                        quotient_o  <= '0;
                        busy_o      <= 1'b1;
                        state       <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign        <= a_reg[W-1] ^ b_reg[W-1];
                    exp_q       <= exp_diff;
                    rem         <= {2'b01, fa};
                    mb          <= {1'b1, fb};
                    q           <= '0;
                    cnt         <= '0;
                    is_special  <= 1'b1;
                    pend_nan    <= 1'b0;
                    pend_inf    <= 1'b0;
                    pend_dz     <= 1'b0;
                    state       <= S_PACK;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        pend_result <= QNAN;
                        pend_nan    <= 1'b1;
                    end else if (a_inf) begin
                        pend_result <= {a_reg[W-1] ^ b_reg[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        pend_inf    <= 1'b1;
                    end else if (b_zero) begin
                        pend_result <= {a_reg[W-1] ^ b_reg[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        pend_inf    <= 1'b1;
                        pend_dz     <= 1'b1;
                    end else if (b_inf || a_zero) begin
                        pend_result <= {a_reg[W-1] ^ b_reg[W-1], {(W-1){1'b0}}};
                    end else begin
                        pend_result <= '0;
                        is_special  <= 1'b0;
                        state       <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem <= rem_next << 1;
                    q   <= {q[MAN_W:0], rem_ge};
                    if (cnt == CNT_W'(MAN_W + 1)) begin
                        state <= S_NORMALIZE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_NORMALIZE: begin
                    if (!q[MAN_W+1]) begin
                        q     <= q << 1;
                        exp_q <= exp_q - 1'b1;
                    end
                    state <= S_PACK;
                end
                S_PACK: begin
                    if (is_special) begin
                        quotient_o <= pend_result;
                        nan_o      <= pend_nan;
                        infinit_o  <= pend_inf;
                        div_zero_o <= pend_dz;
                    end else if (exp_q >= EXP_MAX_X) begin
                        quotient_o <= {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        overflow_o <= 1'b1;
                    end else if (exp_q <= ZERO_X) begin
                        quotient_o  <= {sign, {(W-1){1'b0}}};
                        underflow_o <= 1'b1;
                    end else begin
                        quotient_o <= {sign, exp_q[EXP_W-1:0], q[MAN_W:1]};
                    end
                    done_o <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider32fp.sv
// Scoreboard testbench for divider32fp: directed and random divisions
// compared against an arithmetic reference model, plus reset and ignored-start cases.
module tb_divider32fp;

    typedef struct {
        logic [31:0] q;
        logic [4:0]  flags;
        int          lat;
        int          start_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        nan_o;
    logic        infinit_o;
    logic        div_zero_o;
    logic        overflow_o;
    logic        underflow_o;
    logic [31:0] quotient_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    divider32fp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .nan_o       (nan_o),
        .infinit_o   (infinit_o),
        .div_zero_o  (div_zero_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .quotient_o  (quotient_o)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference model: exact truncated quotient from integer arithmetic
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        int     ea, eb, e;
        longint ma, mb, qv;
        bit     s, az, bz, ai, bi, an, bn;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        r.lat = 3;
        r.start_cyc = 0;
        r.flags = 5'b0;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r.q = 32'h7FC00000;
            r.flags = 5'b10000;
        end else if (ai) begin
            r.q = {s, 31'h7F800000};
            r.flags = 5'b01000;
        end else if (bz) begin
            r.q = {s, 31'h7F800000};
            r.flags = 5'b01100;
        end else if (bi || az) begin
            r.q = {s, 31'h0};
        end else begin
            r.lat = 29;
            ma = longint'({1'b1, a[22:0]});
            mb = longint'({1'b1, b[22:0]});
            e  = ea - eb + 127;
            if (ma >= mb) begin
                qv = (ma << 23) / mb;
            end else begin
                qv = (ma << 24) / mb;
                e  = e - 1;
            end
            if (e >= 255) begin
                r.q = {s, 31'h7F800000};
                r.flags = 5'b00010;
            end else if (e <= 0) begin
                r.q = {s, 31'h0};
                r.flags = 5'b00001;
            end else begin
                r.q = {s, e[7:0], qv[22:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        int          sel;
        logic [7:0]  e;
        logic [22:0] f;
        sel = int'($urandom_range(0, 15));
        f   = 23'($urandom);
        if (sel == 0) e = 8'd0;
        else if (sel == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = '0;
        end else if (sel == 15) e = 8'($urandom_range(1, 254));
        else e = 8'($urandom_range(64, 190));
        return {1'($urandom), e, f};
    endfunction

    // Monitor: pop and compare an expected result on every done pulse
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", {31'b0, done_o}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("quotient", quotient_o, e.q);
                checkOutput("flags", {27'b0, nan_o, infinit_o, div_zero_o, overflow_o, underflow_o},
                            {27'b0, e.flags});
                checkOutput("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (busy_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (busy_o) checkOutput("idle_timeout", {31'b0, busy_o}, 32'h0);
    endtask

    // Issue one division, then check busy duration and result hold in IDLE
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        waitIdle();
        e = model(a, b);
        e.start_cyc = cyc;
        sb.push_back(e);
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (busy_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", 32'(n), 32'(e.lat));
        @(negedge clk);
        checkOutput("hold_quotient", quotient_o, e.q);
        checkOutput("hold_flags", {27'b0, nan_o, infinit_o, div_zero_o, overflow_o, underflow_o},
                    {27'b0, e.flags});
    endtask

    initial begin
        logic [31:0] dir_a[13];
        logic [31:0] dir_b[13];
        exp_t        first;
        int          n;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {25'b0, busy_o, done_o, nan_o, infinit_o, div_zero_o, overflow_o, underflow_o},
                    32'h0);
        checkOutput("reset_quotient", quotient_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        dir_a = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000,
                  32'h00000000, 32'h7FC00001, 32'h7F000000, 32'h00800000, 32'h00000001,
                  32'h7F800000, 32'h3F800000, 32'h7F800000};
        dir_b = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000,
                  32'h00000000, 32'h3F800000, 32'h3E800000, 32'h40000000, 32'h3F800000,
                  32'hC0000000, 32'hFF800000, 32'h7F800000};
        for (int i = 0; i < 13; i++) applyStimulus(dir_a[i], dir_b[i]);

        for (int i = 0; i < 200; i++) applyStimulus(rand_operand(), rand_operand());

        // Reset in the middle of a division aborts it without a done pulse
        waitIdle();
        a_i = 32'h40C00000;
        b_i = 32'h40000000;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("busy_before_abort", {31'b0, busy_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs",
                    {25'b0, busy_o, done_o, nan_o, infinit_o, div_zero_o, overflow_o, underflow_o},
                    32'h0);
        checkOutput("abort_quotient", quotient_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        applyStimulus(32'h40C00000, 32'h40000000);

        // Start pulses while busy and in the DONE cycle are ignored
        waitIdle();
        first = model(32'h3F800000, 32'h40400000);
        first.start_cyc = cyc;
        sb.push_back(first);
        a_i = 32'h3F800000;
        b_i = 32'h40400000;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        a_i = 32'h7F800000;
        b_i = 32'h00000000;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!done_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("done_seen", {31'b0, done_o}, 32'h1);
        a_i = 32'h40C00000;
        b_i = 32'h3F800000;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ignored_start_busy", {31'b0, busy_o}, 32'h0);
        checkOutput("ignored_start_quotient", quotient_o, first.q);
        checkOutput("ignored_start_flags",
                    {27'b0, nan_o, infinit_o, div_zero_o, overflow_o, underflow_o},
                    {27'b0, first.flags});
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
